dct4x4_stream: RTL and testbench

- Streaming 2-D 4x4 forward integer DCT, parametrised in sample width.
- Uses the same H.264-style 4-point butterfly (coefficients 1/1/1/1, 2/1/-1/-2, 1/-1/-1/1, 1/-2/2/-1) as the existing 1-D combinational DCT.
- Accepts one 4-sample row per beat. A row pass feeds a double-buffered transpose store, and a registered column pass emits one 4-coefficient row per beat.
- Sits between the pixel/residual source and the quantiser. Uses valid/ready handshakes on both sides.

---
 rtl/dct4x4_stream.sv | 194 +++++++++++++++++++
 tb/tb_dct4x4_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct4x4_stream.sv
// Streaming 2-D 4x4 forward integer DCT (H.264-style butterfly).
// Each accepted input row goes through the 1-D transform and is stored in one
// of two transpose banks. A completed bank is read back column-wise, and one
// coefficient row per beat is presented through a registered valid/ready output.
module dct4x4_stream #(
    parameter int DW = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [4*DW-1:0]     dt_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4*(DW+6)-1:0] coef_o,
    output logic [1:0]          row_idx_o,
    output logic                blk_start_o
);
    localparam int OW = DW + 6;   // column-pass (output) width
    localparam int RW = DW + 3;   // row-pass (stored) width

    // 1-D butterfly at row-pass width; result packed {y3,y2,y1,y0}
    function automatic logic [4*RW-1:0] t_row(input logic signed [RW-1:0] x0, x1, x2, x3);
        logic signed [RW-1:0] a0, a1, a2, a3;
        a0 = x0 + x3;
        a1 = x1 + x2;
        a2 = x1 - x2;
        a3 = x0 - x3;
        return {a3 - a2 - a2, a0 - a1, a2 + a3 + a3, a0 + a1};
    endfunction

    // 1-D butterfly at output width; result packed {y3,y2,y1,y0}
    function automatic logic [4*OW-1:0] t_col(input logic signed [OW-1:0] x0, x1, x2, x3);
        logic signed [OW-1:0] a0, a1, a2, a3;
        a0 = x0 + x3;
        a1 = x1 + x2;
        a2 = x1 - x2;
        a3 = x0 - x3;
        return {a3 - a2 - a2, a0 - a1, a2 + a3 + a3, a0 + a1};
    endfunction

    logic [RW-1:0]        bank_q [2][4][4];
    logic [RW-1:0]        bank_d [2][4][4];
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           wr_row_q, wr_row_d;
    logic [1:0]           rd_row_q, rd_row_d;
    logic                 out_valid_q, out_valid_d;
    logic [4*OW-1:0]      coef_q, coef_d;
    logic [1:0]           row_idx_q, row_idx_d;
    logic                 blk_start_q, blk_start_d;

    logic signed [RW-1:0] xr_s [4];
    logic [4*RW-1:0]      ry_s;
    logic [RW-1:0]        row_s [4];
    logic signed [OW-1:0] xc_s [4];
    logic [4*OW-1:0]      cy_s;
    logic [4*OW-1:0]      coef_s;
    logic                 accept_s;
    logic                 load_s;

    // Writer stalls only when the bank it would fill still holds an unread block
    assign in_ready_o  = !full_q[wr_bank_q];
    assign accept_s    = in_valid_i && in_ready_o;
    assign load_s      = full_q[rd_bank_q] && (!out_valid_q || out_ready_i);

    assign out_valid_o = out_valid_q;
    assign coef_o      = coef_q;
    assign row_idx_o   = row_idx_q;
    assign blk_start_o = blk_start_q;

    // Row pass: sign-extend the incoming samples and transform them horizontally
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xr_s[k] = {{3{dt_i[k*DW+DW-1]}}, dt_i[k*DW +: DW]};
        end
        ry_s = t_row(xr_s[0], xr_s[1], xr_s[2], xr_s[3]);
        for (int k = 0; k < 4; k++) begin
            row_s[k] = ry_s[k*RW +: RW];
        end
    end

    // Column pass: transform each stored column and pick vertical frequency rd_row
    always_comb begin
        coef_s = '0;
        cy_s   = '0;
        for (int r = 0; r < 4; r++) begin
            xc_s[r] = '0;
        end
        for (int u = 0; u < 4; u++) begin
            for (int r = 0; r < 4; r++) begin
                xc_s[r] = {{3{bank_q[rd_bank_q][r][u][RW-1]}}, bank_q[rd_bank_q][r][u]};
            end
            cy_s = t_col(xc_s[0], xc_s[1], xc_s[2], xc_s[3]);
            coef_s[u*OW +: OW] = cy_s[rd_row_q*OW +: OW];
        end
    end

    // Next-state: bank writes, bank ownership and the output register
    always_comb begin
        bank_d      = bank_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_row_d    = wr_row_q;
        rd_row_d    = rd_row_q;
        out_valid_d = out_valid_q;
        coef_d      = coef_q;
        row_idx_d   = row_idx_q;
        blk_start_d = blk_start_q;
        if (clr_i) begin
            // Bank contents may stay: an empty bank is always fully rewritten before use
            full_d      = 2'b00;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            wr_row_d    = 2'd0;
            rd_row_d    = 2'd0;
            out_valid_d = 1'b0;
            coef_d      = '0;
            row_idx_d   = 2'd0;
            blk_start_d = 1'b0;
        end else begin
            if (accept_s) begin
                for (int k = 0; k < 4; k++) begin
                    bank_d[wr_bank_q][wr_row_q][k] = row_s[k];
                end
                wr_row_d = wr_row_q + 2'd1;
                if (wr_row_q == 2'd3) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wr_bank_d = wr_bank_q;
                end
            end else begin
                wr_row_d = wr_row_q;
            end
            // Reader and writer never share a bank, so both full bits may change together
            if (load_s) begin
                coef_d      = coef_s;
                row_idx_d   = rd_row_q;
                blk_start_d = (rd_row_q == 2'd0);
                out_valid_d = 1'b1;
                rd_row_d    = rd_row_q + 2'd1;
                if (rd_row_q == 2'd3) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    rd_bank_d = rd_bank_q;
                end
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
                blk_start_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int k = 0; k < 4; k++) begin
                        bank_q[b][r][k] <= '0;
                    end
                end
            end
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_row_q    <= 2'd0;
            rd_row_q    <= 2'd0;
            out_valid_q <= 1'b0;
            coef_q      <= '0;
            row_idx_q   <= 2'd0;
            blk_start_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_row_q    <= wr_row_d;
            rd_row_q    <= rd_row_d;
            out_valid_q <= out_valid_d;
            coef_q      <= coef_d;
            row_idx_q   <= row_idx_d;
            blk_start_q <= blk_start_d;
        end
    end

endmodule

// File: tb/tb_dct4x4_stream.sv
// Self-checking bench for dct4x4_stream: directed blocks with known coefficients
// plus random blocks checked against a matrix-product reference C*X*C^T.
module tb_dct4x4_stream;
    localparam int DW = 8;
    localparam int OW = DW + 6;

    logic            clk_i       = 1'b0;
    logic            rst_ni      = 1'b0;
    logic            clr_i       = 1'b0;
    logic            in_valid_i  = 1'b0;
    logic            in_ready_o;
    logic [4*DW-1:0] dt_i        = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [4*OW-1:0] coef_o;
    logic [1:0]      row_idx_o;
    logic            blk_start_o;

    dct4x4_stream #(.DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dt_i        (dt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .coef_o      (coef_o),
        .row_idx_o   (row_idx_o),
        .blk_start_o (blk_start_o)
    );

    always #5 clk_i = ~clk_i;

    typedef int blk_t [4][4];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];          // per expected row: v, c0, c1, c2, c3
    int cyc = 0;
    bit tp_on = 1'b0;
    int tp_cnt = 0;
    int tp_first = 0;
    int tp_last = 0;
    int cm[4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: Y = C * X * C^T, row v of Y is vertical frequency v
    task automatic model(input blk_t x, output blk_t y);
        blk_t r;
        for (int i = 0; i < 4; i++)
            for (int u = 0; u < 4; u++) begin
                r[i][u] = 0;
                for (int k = 0; k < 4; k++) r[i][u] += cm[u][k] * x[i][k];
            end
        for (int v = 0; v < 4; v++)
            for (int u = 0; u < 4; u++) begin
                y[v][u] = 0;
                for (int i = 0; i < 4; i++) y[v][u] += cm[v][i] * r[i][u];
            end
    endtask

    task automatic push_exp(input int v, input int c0, input int c1, input int c2, input int c3);
        exp_q.push_back(v);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
    endtask

    task automatic push_blk(input blk_t y);
        for (int v = 0; v < 4; v++) push_exp(v, y[v][0], y[v][1], y[v][2], y[v][3]);
    endtask

    task automatic send_row(input int a0, input int a1, input int a2, input int a3, output int waits);
        int a[4];
        a = '{a0, a1, a2, a3};
        for (int k = 0; k < 4; k++) dt_i[k*DW +: DW] = a[k][DW-1:0];
        in_valid_i = 1'b1;
        waits = 0;
        @(negedge clk_i);
        while (!in_ready_o && waits < 100) begin
            waits++;
            @(negedge clk_i);
        end
        if (waits >= 100) check_eq("send_timeout", waits, 0);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_blk(input blk_t x, input bit chk_stall);
        int w;
        for (int r = 0; r < 4; r++) begin
            send_row(x[r][0], x[r][1], x[r][2], x[r][3], w);
            if (chk_stall) check_eq("tp_stall", w, 0);
        end
    endtask

    task automatic rand_blk(output blk_t x);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) x[r][k] = int'($urandom_range(255, 0)) - 128;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 300) begin
            @(posedge clk_i);
            w++;
        end
        check_eq("drain_done", exp_q.size(), 0);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Cycle counter used for output spacing
    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor: a row transfers on the next edge when valid && ready now
    always @(negedge clk_i) begin
        int v;
        logic signed [OW-1:0] c;
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() < 5) begin
                check_eq("unexpected_row", exp_q.size(), 5);
            end else begin
                v = exp_q.pop_front();
                check_eq("row_idx", row_idx_o, v);
                check_eq("blk_start", blk_start_o, (v == 0));
                for (int u = 0; u < 4; u++) begin
                    c = coef_o[u*OW +: OW];
                    check_eq($sformatf("coef_v%0d_u%0d", v, u), c, exp_q.pop_front());
                end
            end
            if (tp_on) begin
                if (tp_cnt == 0) tp_first = cyc;
                tp_last = cyc;
                tp_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t b, y, b1, b2, b3, y1, y2, y3;
        int w;
        logic signed [OW-1:0] c;

        #23 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("rst_valid", out_valid_o, 0);
        check_eq("rst_coef", coef_o, 0);
        check_eq("rst_row_idx", row_idx_o, 0);
        check_eq("rst_in_ready", in_ready_o, 1);

        // DC block
        out_ready_i = 1'b1;
        b = '{default: 127};
        push_exp(0, 2032, 0, 0, 0);
        for (int v = 1; v < 4; v++) push_exp(v, 0, 0, 0, 0);
        send_blk(b, 1'b0);
        check_eq("lat_before", out_valid_o, 0);
        @(posedge clk_i);
        #1;
        check_eq("lat_valid", out_valid_o, 1);
        drain();

        // Ramp
        for (int r = 0; r < 4; r++) b[r] = '{1, 2, 3, 4};
        push_exp(0, 40, -28, 0, -4);
        for (int v = 1; v < 4; v++) push_exp(v, 0, 0, 0, 0);
        send_blk(b, 1'b0);
        drain();

        // Extremes
        b[0] = '{-128, -128, 127, 127};
        b[1] = '{-128, -128, 127, 127};
        b[2] = '{127, 127, -128, -128};
        b[3] = '{127, 127, -128, -128};
        push_exp(0, -8, 0, 0, 0);
        push_exp(1, 0, -4590, 0, 1530);
        push_exp(2, 0, 0, 0, 0);
        push_exp(3, 0, 1530, 0, -510);
        send_blk(b, 1'b0);
        drain();

        // Back-pressure: two blocks fill both banks while downstream stalls
        out_ready_i = 1'b0;
        rand_blk(b1); rand_blk(b2); rand_blk(b3);
        model(b1, y1); model(b2, y2); model(b3, y3);
        push_blk(y1); push_blk(y2); push_blk(y3);
        send_blk(b1, 1'b0);
        send_blk(b2, 1'b0);
        check_eq("bp_in_ready_low", in_ready_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_eq("bp_in_ready_hold", in_ready_o, 0);
            check_eq("bp_valid_hold", out_valid_o, 1);
            check_eq("bp_idx_hold", row_idx_o, 0);
            for (int u = 0; u < 4; u++) begin
                c = coef_o[u*OW +: OW];
                check_eq("bp_coef_hold", c, y1[0][u]);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("bp_free_1", in_ready_o, 0);
        @(posedge clk_i); #1;
        check_eq("bp_free_2", in_ready_o, 0);
        @(posedge clk_i); #1;
        check_eq("bp_free_3", in_ready_o, 1);
        send_blk(b3, 1'b0);
        drain();

        // Flush of a partial block
        rand_blk(b);
        send_row(b[0][0], b[0][1], b[0][2], b[0][3], w);
        send_row(b[1][0], b[1][1], b[1][2], b[1][3], w);
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        check_eq("clr_in_ready", in_ready_o, 1);
        check_eq("clr_valid", out_valid_o, 0);
        b = '{default: 1};
        push_exp(0, 16, 0, 0, 0);
        for (int v = 1; v < 4; v++) push_exp(v, 0, 0, 0, 0);
        send_blk(b, 1'b0);
        drain();

        // Asynchronous reset while a block is being emitted
        rand_blk(b1);
        model(b1, y1);
        push_blk(y1);
        send_blk(b1, 1'b0);
        send_row(3, 3, 3, 3, w);
        send_row(5, 5, 5, 5, w);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check_eq("arst_valid", out_valid_o, 0);
        check_eq("arst_coef", coef_o, 0);
        check_eq("arst_in_ready", in_ready_o, 1);
        #10 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        b = '{default: 1};
        push_exp(0, 16, 0, 0, 0);
        for (int v = 1; v < 4; v++) push_exp(v, 0, 0, 0, 0);
        send_blk(b, 1'b0);
        drain();

        // Throughput: 8 random back-to-back blocks with ready high
        tp_on = 1'b1;
        for (int n = 0; n < 8; n++) begin
            rand_blk(b);
            model(b, y);
            push_blk(y);
            send_blk(b, 1'b1);
        end
        drain();
        tp_on = 1'b0;
        check_eq("tp_rows", tp_cnt, 32);
        check_eq("tp_span", tp_last - tp_first, 31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
